// File: rtl/arb_pkg.sv
// Shared types and defaults for the get_data round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    STREAM = 2'd2
  } arb_state_e;

  localparam int DW_DEF          = 32;
  localparam int TIMEOUT_CYC_DEF = 256;

endpackage

// File: rtl/get_data_arbiter_if.sv
// Requester-side and generator-side streaming bus of the get_data arbiter.
interface get_data_arbiter_if
  import arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req_start;
  logic [N_REQ*DW-1:0] req_addr;
  logic [N_REQ-1:0]    req_ack;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_done;
  logic signed [DW-1:0] req_out0;

  logic signed [DW-1:0] gen_addr;
  logic                 gen_start;
  logic                 gen_ready;
  logic                 gen_reset;
  logic                 gen_valid;
  logic                 gen_done;
  logic signed [DW-1:0] gen_out0;

  modport master (
    input  req_start, req_addr, req_ready, gen_valid, gen_done, gen_out0,
    output req_ack, req_valid, req_done, req_out0,
           gen_addr, gen_start, gen_ready, gen_reset
  );

  modport slave (
    output req_start, req_addr, req_ready, gen_valid, gen_done, gen_out0,
    input  req_ack, req_valid, req_done, req_out0,
           gen_addr, gen_start, gen_ready, gen_reset
  );

endinterface

// File: rtl/get_data_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, with wrap.
module rr_pick #(
  parameter int  N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int off;
  int best_off;

  // Distance from ptr (mod N_REQ) ranks each requester; smallest distance wins.
  always_comb begin
    idx      = '0;
    any      = 1'b0;
    off      = 0;
    best_off = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
      if (req[i] && (off < best_off)) begin
        best_off = off;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/get_data_arbiter.sv
// Round-robin arbiter sharing one get_data generator among N_REQ requesters.
// Optional stall timeout is built when ARB_TIMEOUT_EN is defined.
module get_data_arbiter
  import arb_pkg::*;
#(
  parameter int  N_REQ       = 2,
  parameter int  DW          = DW_DEF,
  parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic                      _clock,
  input  logic                      _reset,
  get_data_arbiter_if.master        bus,
  output logic [IW-1:0]             owner,
  output logic                      busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
    $error("get_data_arbiter: unsupported N_REQ/TIMEOUT_CYC");
  end

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic signed [DW-1:0] addr_q, addr_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] own_oh;
  logic             own_ready;
  logic             finish;
  logic             timeout_hit;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] k);
    return (k == IW'(N_REQ - 1)) ? '0 : k + IW'(1);
  endfunction

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req_start),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_oh    = N_REQ'(1) << owner_q;
  assign own_ready = bus.req_ready[owner_q];
  assign finish    = (state_q == STREAM) && bus.gen_valid && bus.gen_done && own_ready;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LIM = 16'(TIMEOUT_CYC - 1);
  logic [15:0] stall_q;
  logic        beat;

  assign beat = bus.gen_valid && own_ready;

  // Counter is held at zero outside STREAM, so entering STREAM starts it clean.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      stall_q <= '0;
    end else if (state_q != STREAM || beat) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign timeout_hit   = (state_q == STREAM) && (stall_q == STALL_LIM) && !beat;
  assign timeout_err   = timeout_hit;
  assign bus.gen_reset = _reset | timeout_hit;
`else
  assign timeout_hit   = 1'b0;
  assign bus.gen_reset = _reset;
`endif

  // ---- state register ----
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          addr_d  = $signed(bus.req_addr[int'(pick_idx)*DW +: DW]);
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = STREAM;
      STREAM: begin
        if (finish || timeout_hit) begin
          rr_ptr_d = rr_next(owner_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs: launch pulse and owner pass-through ----
  always_comb begin
    bus.req_ack   = '0;
    bus.req_valid = '0;
    bus.req_done  = '0;
    bus.req_out0  = '0;
    bus.gen_ready = 1'b0;
    bus.gen_start = 1'b0;
    case (state_q)
      LAUNCH: begin
        bus.gen_start = 1'b1;
        bus.req_ack   = own_oh;
      end
      STREAM: begin
        if (timeout_hit) begin
          bus.req_valid = own_oh;
          bus.req_done  = own_oh;
        end else begin
          bus.gen_ready = own_ready;
          bus.req_valid = bus.gen_valid ? own_oh : '0;
          bus.req_done  = bus.gen_done ? own_oh : '0;
          bus.req_out0  = bus.gen_out0;
        end
      end
      default: ;
    endcase
  end

  assign bus.gen_addr = addr_q;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);

endmodule
